// File: rtl/bram_req_adapter_pkg.sv
// Shared types and helpers for the BRAM request adapter.
package bram_req_adapter_pkg;

   // Adapter top-level state: zeroing sweep after reset, then normal traffic.
   typedef enum logic [0:0] {ST_INIT, ST_RUN} state_e;

   // A new response-producing request may issue only if every response already owed
   // (buffered entries plus the one whose RAM data is arriving this cycle) still leaves a
   // free slot. Pops in the same cycle are deliberately not credited, so the ready path
   // never sees the consumer.
   function automatic logic credit_ok(input int unsigned occ, input int unsigned pend,
                                      input int unsigned depth);
      return (occ + pend) < depth;
   endfunction

endpackage

// File: rtl/bram_resp_fifo.sv
// In-order synchronous FIFO for read responses; push and pop may coincide at any
// occupancy, including full. Exposes its occupancy for credit accounting.
module bram_resp_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 3,
   localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
   input  logic             clka,
   input  logic             rsta,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full     = (count_q == CW'(DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign pop_data = mem_q[rd_ptr_q];
   // A full buffer can still take a push when the head leaves in the same cycle.
   assign do_push  = push && (!full || pop);
   assign do_pop   = pop && !empty;

   // Pointer wrap (depth need not be a power of two) and occupancy update.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
      end
      if (do_push && !do_pop) begin
         count_d = count_q + CW'(1);
      end else if (do_pop && !do_push) begin
         count_d = count_q - CW'(1);
      end
   end

   // Pointer and occupancy registers; reset flushes the buffer.
   always_ff @(posedge clka) begin
      if (rsta) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents are meaningless outside the occupied window, so no reset.
   always_ff @(posedge clka) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

endmodule

// File: rtl/bram_req_adapter.sv
// Valid/ready front-end for a single-port no-change BRAM with 1-cycle read latency.
// Zeroes the array after reset, then turns reads into in-order, buffered responses.
// Optional build macro BRAM_REQ_ADAPTER_WRITE_ACK_EN: writes consume a credit and return
// an in-order response (rdata 0, resp_is_write 1).
module bram_req_adapter
   import bram_req_adapter_pkg::*;
#(
   parameter int unsigned RAM_WIDTH  = 18,
   parameter int unsigned RAM_DEPTH  = 1024,
   parameter int unsigned TAG_W      = 4,
   parameter int unsigned RESP_DEPTH = 3,
   parameter int unsigned INIT_SWEEP = 1,
   localparam int unsigned AW        = $clog2(RAM_DEPTH)
) (
   input  logic                 clka,
   input  logic                 rsta,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_we,
   input  logic [AW-1:0]        req_addr,
   input  logic [RAM_WIDTH-1:0] req_wdata,
   input  logic [TAG_W-1:0]     req_tag,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [RAM_WIDTH-1:0] resp_rdata,
   output logic [TAG_W-1:0]     resp_tag,
`ifdef BRAM_REQ_ADAPTER_WRITE_ACK_EN
   output logic                 resp_is_write,
`endif
   output logic                 init_done,
   output logic [AW-1:0]        ram_addra,
   output logic [RAM_WIDTH-1:0] ram_dina,
   output logic                 ram_wea,
   output logic                 ram_ena,
   output logic                 ram_regcea,
   output logic                 ram_rsta,
   input  logic [RAM_WIDTH-1:0] ram_douta
);

   localparam int unsigned CW = $clog2(RESP_DEPTH + 1);
   // Sweep counter is one bit wider than the address so the terminal compare is exact.
   localparam logic [AW:0] CNT_LAST = (AW + 1)'(RAM_DEPTH - 1);

   // Field widths follow this instance's parameters, so the entry type lives here.
   typedef struct packed {
      logic [RAM_WIDTH-1:0] rdata;
      logic [TAG_W-1:0]     tag;
      logic                 is_write;
   } resp_entry_t;

   localparam int unsigned EW = $bits(resp_entry_t);

   state_e           state_q, state_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             pend_q, pend_d;
   logic             pend_wr_q, pend_wr_d;
   logic [TAG_W-1:0] tag_q, tag_d;

   logic [CW-1:0]    occ;
   logic             fifo_full;
   logic             fifo_empty;
   logic             credit;
   logic             accept;
   resp_entry_t      push_entry;
   resp_entry_t      head_entry;

   assign credit = credit_ok(32'(occ), 32'(pend_q), RESP_DEPTH);

   // Next-state, sweep counter, credit gating and RAM port drive.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      pend_d     = 1'b0;
      pend_wr_d  = 1'b0;
      tag_d      = tag_q;
      req_ready  = 1'b0;
      accept     = 1'b0;
      ram_ena    = 1'b0;
      ram_wea    = 1'b0;
      ram_addra  = req_addr;
      ram_dina   = req_wdata;
      unique case (state_q)
         ST_INIT: begin
            ram_ena   = 1'b1;
            ram_wea   = 1'b1;
            ram_addra = cnt_q[AW-1:0];
            ram_dina  = '0;
            cnt_d     = cnt_q + (AW + 1)'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
`ifdef BRAM_REQ_ADAPTER_WRITE_ACK_EN
            req_ready = credit;
`else
            // Writes produce no response, so they never wait for buffer space.
            req_ready = req_we || credit;
`endif
            accept  = req_valid && req_ready;
            ram_ena = accept;
            ram_wea = accept && req_we;
`ifdef BRAM_REQ_ADAPTER_WRITE_ACK_EN
            pend_d    = accept;
            pend_wr_d = accept && req_we;
`else
            pend_d    = accept && !req_we;
`endif
            if (pend_d) begin
               tag_d = req_tag;
            end
         end
      endcase
      // Nothing reaches the RAM or the requester while reset is held.
      if (rsta) begin
         req_ready = 1'b0;
         accept    = 1'b0;
         ram_ena   = 1'b0;
         ram_wea   = 1'b0;
      end
   end

   // State, sweep counter and in-flight read bookkeeping.
   always_ff @(posedge clka) begin
      if (rsta) begin
         state_q   <= (INIT_SWEEP != 0) ? ST_INIT : ST_RUN;
         cnt_q     <= '0;
         pend_q    <= 1'b0;
         pend_wr_q <= 1'b0;
         tag_q     <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pend_q    <= pend_d;
         pend_wr_q <= pend_wr_d;
         tag_q     <= tag_d;
      end
   end

   // RAM data is valid the cycle after issue; capture it with the tag issued alongside.
   always_comb begin
      push_entry.rdata    = pend_wr_q ? '0 : ram_douta;
      push_entry.tag      = tag_q;
      push_entry.is_write = pend_wr_q;
   end

   bram_resp_fifo #(
      .WIDTH (EW),
      .DEPTH (RESP_DEPTH)
   ) u_resp_fifo (
      .clka      (clka),
      .rsta      (rsta),
      .push      (pend_q),
      .push_data (push_entry),
      .pop       (resp_valid && resp_ready),
      .pop_data  (head_entry),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (occ)
   );

   assign resp_valid = !fifo_empty;
   assign resp_rdata = head_entry.rdata;
   assign resp_tag   = head_entry.tag;
   assign init_done  = (state_q == ST_RUN) && !rsta;
   assign ram_regcea = 1'b1;
   assign ram_rsta   = rsta;

`ifdef BRAM_REQ_ADAPTER_WRITE_ACK_EN
   assign resp_is_write = head_entry.is_write;
   logic unused_sig;
   assign unused_sig = fifo_full;
`else
   logic unused_sig;
   assign unused_sig = fifo_full ^ head_entry.is_write;
`endif

endmodule

// File: tb/tb_bram_req_adapter.sv
// Scoreboard bench for bram_req_adapter with a behavioural no-change BRAM attached.
module tb_bram_req_adapter;

   localparam int unsigned W  = 18;
   localparam int unsigned D  = 16;
   localparam int unsigned TW = 4;
   localparam int unsigned RD = 3;
   localparam int unsigned AW = 4;

   logic          clka = 1'b0;
   logic          rsta;
   logic          req_valid, req_ready, req_we;
   logic [AW-1:0] req_addr;
   logic [W-1:0]  req_wdata;
   logic [TW-1:0] req_tag;
   logic          resp_valid, resp_ready;
   logic [W-1:0]  resp_rdata;
   logic [TW-1:0] resp_tag;
   logic          init_done;
   logic [AW-1:0] ram_addra;
   logic [W-1:0]  ram_dina;
   logic          ram_wea, ram_ena, ram_regcea, ram_rsta;
   logic [W-1:0]  ram_douta;

   bram_req_adapter #(
      .RAM_WIDTH  (W),
      .RAM_DEPTH  (D),
      .TAG_W      (TW),
      .RESP_DEPTH (RD),
      .INIT_SWEEP (1)
   ) dut (
      .clka       (clka),
      .rsta       (rsta),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_tag    (req_tag),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_tag   (resp_tag),
      .init_done  (init_done),
      .ram_addra  (ram_addra),
      .ram_dina   (ram_dina),
      .ram_wea    (ram_wea),
      .ram_ena    (ram_ena),
      .ram_regcea (ram_regcea),
      .ram_rsta   (ram_rsta),
      .ram_douta  (ram_douta)
   );

   always #5 clka = ~clka;

   // No-change single-port BRAM: output updates only on an enabled read.
   logic [W-1:0] bram [D];
   always @(posedge clka) begin
      if (ram_ena) begin
         if (ram_wea) bram[ram_addra] <= ram_dina;
         else         ram_douta <= bram[ram_addra];
      end
   end

   typedef struct {
      logic [W-1:0]  rdata;
      logic [TW-1:0] tag;
   } exp_t;

   exp_t         exp_q [$];
   logic [W-1:0] ref_mem [D];
   logic [W-1:0] last_rdata;
   int           n_vec = 0;
   int           n_err = 0;
   int           n_acc = 0;
   int           n_pop = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference model: memory contents as the requester sees them, plus owed responses.
   always @(negedge clka) begin
      if (rsta) begin
         exp_q.delete();
         for (int i = 0; i < D; i++) ref_mem[i] = '0;
      end else if (req_valid && req_ready) begin
         n_acc++;
         if (req_we) ref_mem[req_addr] = req_wdata;
         else        exp_q.push_back('{ref_mem[req_addr], req_tag});
      end
   end

   // Monitor: every delivered response must match the oldest owed one.
   always @(negedge clka) begin
      if (!rsta && resp_valid && resp_ready) begin
         exp_t e;
         n_pop++;
         last_rdata = resp_rdata;
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL resp_unexpected: got tag %0h data %0h, expected none", resp_tag,
                     resp_rdata);
         end else begin
            e = exp_q.pop_front();
            chk("resp_rdata", 32'(resp_rdata), 32'(e.rdata));
            chk("resp_tag", 32'(resp_tag), 32'(e.tag));
         end
      end
   end

   task automatic cyc();
      @(posedge clka);
      #1;
   endtask

   task automatic idle();
      req_valid = 1'b0;
      req_we    = 1'b0;
   endtask

   task automatic drive(input logic we, input logic [AW-1:0] a, input logic [W-1:0] d,
                        input logic [TW-1:0] t);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      req_tag   = t;
   endtask

   task automatic wait_drain();
      int k;
      k = 0;
      while ((exp_q.size() != 0 || resp_valid) && k < 64) begin
         cyc();
         k++;
      end
      if (k == 64) chk("drain_timeout", 32'(exp_q.size()), 0);
   endtask

   task automatic reset_sweep(input bit check);
      int bad;
      int k;
      rsta = 1'b1;
      idle();
      cyc();
      cyc();
      if (check) begin
         chk("rst_req_ready", 32'(req_ready), 0);
         chk("rst_resp_valid", 32'(resp_valid), 0);
         chk("rst_init_done", 32'(init_done), 0);
         chk("rst_ram_ena", 32'(ram_ena), 0);
         chk("rst_ram_wea", 32'(ram_wea), 0);
      end
      rsta = 1'b0;
      if (check) begin
         // A read waits at the port for the whole sweep and must not be taken.
         drive(1'b0, 4'd9, '0, 4'd0);
         bad = 0;
         for (int i = 0; i < D; i++) begin
            @(negedge clka);
            if (init_done !== 1'b0 || req_ready !== 1'b0 || ram_ena !== 1'b1 ||
                ram_wea !== 1'b1 || ram_dina !== '0 || ram_addra !== 4'(i)) bad++;
            cyc();
         end
         idle();
         chk("sweep_seq", 32'(bad), 0);
         @(negedge clka);
         chk("sweep_init_done", 32'(init_done), 1);
         chk("sweep_run_ready", 32'(req_ready), 1);
         cyc();
      end else begin
         k = 0;
         while (!init_done && k < D + 4) begin
            cyc();
            k++;
         end
         chk("resweep_done", 32'(init_done), 1);
      end
   endtask

   initial begin
      int            acc0, pop0, bad_rdy, bad_val;
      logic [AW-1:0] a, b;
      rsta       = 1'b1;
      resp_ready = 1'b1;
      req_addr   = '0;
      req_wdata  = '0;
      req_tag    = '0;
      idle();

      // Sweep, then a read of a swept entry returns zero.
      reset_sweep(1'b1);
      drive(1'b0, 4'd7, '0, 4'd1);
      cyc();
      idle();
      wait_drain();

      // Write then read same address: new data, 2-cycle latency.
      drive(1'b1, 4'd3, 18'h2A5B7, 4'd0);
      cyc();
      drive(1'b0, 4'd3, '0, 4'd5);
      @(negedge clka);
      chk("raw_read_ready", 32'(req_ready), 1);
      cyc();
      idle();
      @(negedge clka);
      chk("lat_n1_valid", 32'(resp_valid), 0);
      cyc();
      @(negedge clka);
      chk("lat_n2_valid", 32'(resp_valid), 1);
      chk("raw_rdata", 32'(resp_rdata), 32'h2A5B7);
      chk("raw_tag", 32'(resp_tag), 5);
      cyc();
      wait_drain();

      // Back-pressure: exactly RD reads fit, head held steady.
      resp_ready = 1'b0;
      acc0 = n_acc;
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 4'($urandom_range(0, D - 1)), '0, 4'(i));
         cyc();
      end
      @(negedge clka);
      chk("bp_accepted", 32'(n_acc - acc0), RD);
      chk("bp_ready_low", 32'(req_ready), 0);
      chk("bp_head_tag", 32'(resp_tag), 0);
      cyc();
      idle();
      @(negedge clka);
      chk("bp_head_hold", 32'(resp_tag), 0);
      chk("bp_valid_hold", 32'(resp_valid), 1);
      pop0 = n_pop;
      resp_ready = 1'b1;
      wait_drain();
      chk("bp_popped", 32'(n_pop - pop0), RD);

      // Throughput: 20 back-to-back reads, responses on consecutive cycles.
      bad_rdy = 0;
      bad_val = 0;
      for (int i = 0; i < 22; i++) begin
         if (i < 20) drive(1'b0, 4'($urandom_range(0, D - 1)), '0, 4'(i));
         else        idle();
         @(negedge clka);
         if (i < 20 && req_ready !== 1'b1) bad_rdy++;
         if (i >= 2 && resp_valid !== 1'b1) bad_val++;
         cyc();
      end
      chk("tput_ready", 32'(bad_rdy), 0);
      chk("tput_stream", 32'(bad_val), 0);
      wait_drain();

      // Interleave: read A, write B, read A; both reads see the old A data.
      a = 4'($urandom_range(0, D - 1));
      b = 4'((32'(a) + 1 + $urandom_range(0, D - 2)) % D);
      drive(1'b1, a, 18'($urandom), 4'd0);
      cyc();
      drive(1'b0, a, '0, 4'd6);
      cyc();
      drive(1'b1, b, 18'($urandom), 4'd0);
      cyc();
      drive(1'b0, a, '0, 4'd7);
      cyc();
      idle();
      wait_drain();

      // Random traffic with random consumer stalls.
      for (int i = 0; i < 300; i++) begin
         resp_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 3) != 0)
            drive(1'($urandom), 4'($urandom_range(0, D - 1)), 18'($urandom), 4'($urandom));
         else
            idle();
         cyc();
      end
      idle();
      resp_ready = 1'b1;
      wait_drain();

      // Reset with responses buffered: everything dropped, array re-zeroed.
      resp_ready = 1'b0;
      drive(1'b1, a, 18'h3FFFF, 4'd0);
      cyc();
      drive(1'b0, a, '0, 4'd8);
      cyc();
      drive(1'b0, a, '0, 4'd9);
      cyc();
      idle();
      cyc();
      @(negedge clka);
      chk("mid_buffered", 32'(resp_valid), 1);
      cyc();
      rsta = 1'b1;
      cyc();
      @(negedge clka);
      chk("mid_rst_valid", 32'(resp_valid), 0);
      cyc();
      reset_sweep(1'b0);
      resp_ready = 1'b1;
      pop0 = n_pop;
      drive(1'b0, a, '0, 4'd10);
      cyc();
      idle();
      wait_drain();
      chk("post_rst_pops", 32'(n_pop - pop0), 1);
      chk("post_rst_rdata", 32'(last_rdata), 0);

      chk("final_queue_empty", 32'(exp_q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
